i2s_stream_controller: RTL and testbench

Sequencer for the audio output path: owns audio clock-mux selection and sample-size configuration, and gates the I2S shift register's start handshake. Sits between the configuration interface and the sample processor / I2S shift register / audio clock mux. Rate or size changes are applied only at a frame boundary, with the shift register held and the clock allowed to settle. It also counts stream underruns.

---
 rtl/i2s_ctrl_pkg.sv | 39 +++
 rtl/i2s_stream_controller_settle_timer.sv | 31 +++
 rtl/i2s_stream_controller.sv | 154 +++++++++++++++
 tb/tb_i2s_stream_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ctrl_pkg.sv
// Shared definitions for the audio output path: rate codes for the clock
// mux, sample-size codes for the processor and shift register, legality
// helpers and the stream controller state encoding.
package i2s_ctrl_pkg;

  localparam logic [1:0] s_48k   = 2'd0;
  localparam logic [1:0] s_88_2k = 2'd1;
  localparam logic [1:0] s_96k   = 2'd2;

  localparam logic [2:0] S_8BIT  = 3'd0;
  localparam logic [2:0] S_12BIT = 3'd1;
  localparam logic [2:0] S_16BIT = 3'd3;
  localparam logic [2:0] S_24BIT = 3'd4;
  localparam logic [2:0] S_32BIT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_APPLY,
    ST_SETTLE
  } ctrl_state_e;

  function automatic logic rate_legal(input logic [1:0] rate);
    case (rate)
      s_48k, s_88_2k, s_96k: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      S_8BIT, S_12BIT, S_16BIT, S_24BIT, S_32BIT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2s_stream_controller_settle_timer.sv
// settle_timer: 16-bit down counter used to hold the stream after a clock
// or size change.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val into the counter
//   load_val   : initial count
//   count_en   : decrement while nonzero
//   done       : counter is zero
module settle_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        count_en,
  output logic        done
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count_en && (cnt != '0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/i2s_stream_controller.sv
// i2s_stream_controller: sequences the audio output path. Owns the clock-mux
// select and sample size, applies changes only at frame boundaries with the
// shift register held, gates shift-register start pulses and counts
// underruns.
//   cfg_valid/cfg_ready/cfg_rate/cfg_size/cfg_err : configuration request
//   enable, sample_valid, sr_busy, frame_done     : stream status inputs
//   audio_clk_sel, sample_size                    : applied configuration
//   sr_start, sr_hold, running, underruns         : stream control/status
// All outputs are registered.
module i2s_stream_controller
  import i2s_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned UNDERRUN_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_rate,
  input  logic [2:0]            cfg_size,
  output logic                  cfg_err,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic                  sr_busy,
  input  logic                  frame_done,
  output logic [1:0]            audio_clk_sel,
  output logic [2:0]            sample_size,
  output logic                  sr_start,
  output logic                  sr_hold,
  output logic                  running,
  output logic [UNDERRUN_W-1:0] underruns
);

  // Timer reaches zero on the last SETTLE cycle, so it is loaded with N-1.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  ctrl_state_e state, state_nx;

  logic                  pend, pend_nx;
  logic [1:0]            pend_rate, pend_rate_nx;
  logic [2:0]            pend_size, pend_size_nx;
  logic [1:0]            clk_sel_nx;
  logic [2:0]            size_nx;
  logic [UNDERRUN_W-1:0] under_nx;
  logic                  start_nx, err_nx;
  logic                  accept, legal_acc;
  logic                  tmr_load, tmr_done;

  assign accept    = cfg_valid && cfg_ready;
  assign legal_acc = accept && rate_legal(cfg_rate) && size_legal(cfg_size);

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .count_en (state == ST_SETTLE),
    .done     (tmr_done)
  );

  always_comb begin
    state_nx     = state;
    pend_nx      = pend;
    pend_rate_nx = pend_rate;
    pend_size_nx = pend_size;
    clk_sel_nx   = audio_clk_sel;
    size_nx      = sample_size;
    under_nx     = underruns;
    start_nx     = 1'b0;
    err_nx       = accept && !legal_acc;
    tmr_load     = 1'b0;

    if (legal_acc) begin
      pend_nx      = 1'b1;
      pend_rate_nx = cfg_rate;
      pend_size_nx = cfg_size;
    end

    case (state)
      ST_IDLE: begin
        if (legal_acc)   state_nx = ST_APPLY;
        else if (enable) state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (sample_valid) begin
          start_nx = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        // A pending change or stop wins over a frame restart.
        if (legal_acc || !enable) begin
          state_nx = ST_DRAIN;
        end else if (frame_done) begin
          if (sample_valid) begin
            start_nx = 1'b1;
          end else begin
            if (underruns != '1) under_nx = underruns + UNDERRUN_W'(1);
            state_nx = ST_ARM;
          end
        end
      end
      ST_DRAIN: begin
        if (frame_done || !sr_busy) state_nx = pend ? ST_APPLY : ST_IDLE;
      end
      ST_APPLY: begin
        clk_sel_nx = pend_rate;
        size_nx    = pend_size;
        pend_nx    = 1'b0;
        tmr_load   = 1'b1;
        state_nx   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_done) state_nx = enable ? ST_ARM : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pend          <= 1'b0;
      pend_rate     <= s_48k;
      pend_size     <= S_16BIT;
      audio_clk_sel <= s_48k;
      sample_size   <= S_16BIT;
      sr_hold       <= 1'b1;
      cfg_ready     <= 1'b1;
      sr_start      <= 1'b0;
      running       <= 1'b0;
      cfg_err       <= 1'b0;
      underruns     <= '0;
    end else begin
      state         <= state_nx;
      pend          <= pend_nx;
      pend_rate     <= pend_rate_nx;
      pend_size     <= pend_size_nx;
      audio_clk_sel <= clk_sel_nx;
      sample_size   <= size_nx;
      sr_hold       <= (state_nx == ST_IDLE) || (state_nx == ST_APPLY) ||
                       (state_nx == ST_SETTLE);
      cfg_ready     <= (state_nx == ST_IDLE) || (state_nx == ST_RUN);
      sr_start      <= start_nx;
      running       <= (state_nx == ST_RUN);
      cfg_err       <= err_nx;
      underruns     <= under_nx;
    end
  end

endmodule

// File: tb/tb_i2s_stream_controller.sv
module tb_i2s_stream_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_rate;
  logic [2:0] cfg_size;
  logic       cfg_err;
  logic       enable;
  logic       sample_valid;
  logic       sr_busy;
  logic       frame_done;
  logic [1:0] audio_clk_sel;
  logic [2:0] sample_size;
  logic       sr_start;
  logic       sr_hold;
  logic       running;
  logic [7:0] underruns;

  int errors = 0;
  int checks = 0;

  i2s_stream_controller #(.SETTLE_CYCLES(64), .UNDERRUN_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_rate      (cfg_rate),
    .cfg_size      (cfg_size),
    .cfg_err       (cfg_err),
    .enable        (enable),
    .sample_valid  (sample_valid),
    .sr_busy       (sr_busy),
    .frame_done    (frame_done),
    .audio_clk_sel (audio_clk_sel),
    .sample_size   (sample_size),
    .sr_start      (sr_start),
    .sr_hold       (sr_hold),
    .running       (running),
    .underruns     (underruns)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_rate = 2'd0; cfg_size = 3'd0;
    enable = 1'b0; sample_valid = 1'b0; sr_busy = 1'b0; frame_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cfg_ready, sr_hold, sr_start, running, cfg_err} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 11000",
               {cfg_ready, sr_hold, sr_start, running, cfg_err});
    end
    checks++;
    if ({audio_clk_sel, sample_size, underruns} !== {2'd0, 3'd3, 8'd0}) begin
      errors++;
      $display("FAIL reset_cfg: clk_sel=%0d size=%0d underruns=%0d want 0/3/0",
               audio_clk_sel, sample_size, underruns);
    end
  endtask

  task automatic test_start();
    enable = 1'b1; sample_valid = 1'b1;
    tick();  // IDLE -> ARM
    checks++;
    if ({sr_hold, running, cfg_ready, sr_start} !== 4'b0000) begin
      errors++;
      $display("FAIL arm_state: hold/run/ready/start=%b want 0000",
               {sr_hold, running, cfg_ready, sr_start});
    end
    tick();  // ARM -> RUN
    checks++;
    if ({sr_start, running, cfg_ready, audio_clk_sel, sample_size} !== {3'b111, 2'd0, 3'd3}) begin
      errors++;
      $display("FAIL run_entry: start=%b run=%b ready=%b clk_sel=%0d size=%0d want 1 1 1 0 3",
               sr_start, running, cfg_ready, audio_clk_sel, sample_size);
    end
    tick();
    checks++;
    if ({sr_start, running} !== 2'b01) begin
      errors++;
      $display("FAIL start_pulse_width: start/run=%b want 01", {sr_start, running});
    end
  endtask

  task automatic test_back_to_back();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    checks++;
    if ({sr_start, running} !== 2'b11) begin
      errors++;
      $display("FAIL restart: start/run=%b want 11", {sr_start, running});
    end
    tick();
    checks++;
    if ({sr_start, running} !== 2'b01) begin
      errors++;
      $display("FAIL restart_end: start/run=%b want 01", {sr_start, running});
    end
  endtask

  task automatic test_cfg_run();
    sr_busy = 1'b1; cfg_valid = 1'b1; cfg_rate = 2'd2; cfg_size = 3'd4;
    tick();  // RUN -> DRAIN
    cfg_valid = 1'b0;
    checks++;
    if ({running, cfg_ready, sr_hold, sr_start} !== 4'b0000) begin
      errors++;
      $display("FAIL drain_entry: run/ready/hold/start=%b want 0000",
               {running, cfg_ready, sr_hold, sr_start});
    end
    tick(); tick();
    checks++;
    if ({running, sr_start, audio_clk_sel} !== {2'b00, 2'd0}) begin
      errors++;
      $display("FAIL drain_wait: run=%b start=%b clk_sel=%0d want 0 0 0",
               running, sr_start, audio_clk_sel);
    end
    frame_done = 1'b1;
    tick();  // DRAIN -> APPLY
    frame_done = 1'b0; sr_busy = 1'b0;
    checks++;
    if ({sr_start, sr_hold, audio_clk_sel} !== {2'b01, 2'd0}) begin
      errors++;
      $display("FAIL apply_entry: start=%b hold=%b clk_sel=%0d want 0 1 0",
               sr_start, sr_hold, audio_clk_sel);
    end
    tick();  // APPLY -> SETTLE
    checks++;
    if ({sr_hold, audio_clk_sel, sample_size} !== {1'b1, 2'd2, 3'd4}) begin
      errors++;
      $display("FAIL applied: hold=%b clk_sel=%0d size=%0d want 1 2 4",
               sr_hold, audio_clk_sel, sample_size);
    end
    for (int i = 1; i < 64; i++) begin
      tick();
      checks++;
      if ({sr_hold, running} !== 2'b10) begin
        errors++;
        $display("FAIL settle_hold[%0d]: hold/run=%b want 10", i, {sr_hold, running});
      end
    end
    tick();  // SETTLE -> ARM after 64 cycles
    checks++;
    if ({sr_hold, running, sr_start} !== 3'b000) begin
      errors++;
      $display("FAIL settle_exit: hold/run/start=%b want 000", {sr_hold, running, sr_start});
    end
    tick();  // ARM -> RUN
    checks++;
    if ({sr_start, running} !== 2'b11) begin
      errors++;
      $display("FAIL restart_after_cfg: start/run=%b want 11", {sr_start, running});
    end
  endtask

  task automatic test_illegal();
    logic [1:0] rates [2] = '{2'd3, 2'd0};
    logic [2:0] sizes [2] = '{3'd4, 3'd6};
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1; cfg_rate = rates[k]; cfg_size = sizes[k];
      tick();
      cfg_valid = 1'b0;
      checks++;
      if ({cfg_err, running, cfg_ready, audio_clk_sel, sample_size} !== {3'b111, 2'd2, 3'd4}) begin
        errors++;
        $display("FAIL illegal_run[%0d]: err=%b run=%b ready=%b clk_sel=%0d size=%0d want 1 1 1 2 4",
                 k, cfg_err, running, cfg_ready, audio_clk_sel, sample_size);
      end
      tick();
      checks++;
      if ({cfg_err, running} !== 2'b01) begin
        errors++;
        $display("FAIL illegal_run_pulse[%0d]: err/run=%b want 01", k, {cfg_err, running});
      end
    end
    enable = 1'b0;
    tick(); tick();  // RUN -> DRAIN -> IDLE
    checks++;
    if ({cfg_ready, sr_hold, running} !== 3'b110) begin
      errors++;
      $display("FAIL stop_to_idle: ready/hold/run=%b want 110", {cfg_ready, sr_hold, running});
    end
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1; cfg_rate = rates[k]; cfg_size = sizes[k];
      tick();
      cfg_valid = 1'b0;
      checks++;
      if ({cfg_err, cfg_ready, sr_hold, audio_clk_sel, sample_size} !== {3'b111, 2'd2, 3'd4}) begin
        errors++;
        $display("FAIL illegal_idle[%0d]: err=%b ready=%b hold=%b clk_sel=%0d size=%0d want 1 1 1 2 4",
                 k, cfg_err, cfg_ready, sr_hold, audio_clk_sel, sample_size);
      end
      tick();
      checks++;
      if ({cfg_err, cfg_ready, sr_hold} !== 3'b011) begin
        errors++;
        $display("FAIL illegal_idle_pulse[%0d]: err/ready/hold=%b want 011",
                 k, {cfg_err, cfg_ready, sr_hold});
      end
    end
  endtask

  task automatic test_stop_and_cfg();
    enable = 1'b1; sample_valid = 1'b1;
    tick(); tick();  // IDLE -> ARM -> RUN
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL rerun: running=%b want 1", running);
    end
    enable = 1'b0; sr_busy = 1'b0;
    cfg_valid = 1'b1; cfg_rate = 2'd1; cfg_size = 3'd5;
    tick();  // RUN -> DRAIN
    cfg_valid = 1'b0;
    checks++;
    if ({running, cfg_ready, sr_hold} !== 3'b000) begin
      errors++;
      $display("FAIL stop_cfg_drain: run/ready/hold=%b want 000", {running, cfg_ready, sr_hold});
    end
    tick();  // DRAIN -> APPLY
    checks++;
    if ({sr_hold, audio_clk_sel} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL stop_cfg_apply: hold=%b clk_sel=%0d want 1 2", sr_hold, audio_clk_sel);
    end
    tick();  // APPLY -> SETTLE
    checks++;
    if ({audio_clk_sel, sample_size} !== {2'd1, 3'd5}) begin
      errors++;
      $display("FAIL stop_cfg_applied: clk_sel=%0d size=%0d want 1 5", audio_clk_sel, sample_size);
    end
    for (int i = 1; i < 64; i++) tick();
    checks++;
    if ({cfg_ready, sr_hold} !== 2'b01) begin
      errors++;
      $display("FAIL stop_cfg_settle_end: ready/hold=%b want 01", {cfg_ready, sr_hold});
    end
    tick();  // SETTLE -> IDLE
    checks++;
    if ({cfg_ready, sr_hold, running} !== 3'b110) begin
      errors++;
      $display("FAIL stop_cfg_idle: ready/hold/run=%b want 110", {cfg_ready, sr_hold, running});
    end
  endtask

  task automatic test_underrun();
    enable = 1'b1; sample_valid = 1'b1;
    tick(); tick();  // IDLE -> ARM -> RUN
    for (int i = 1; i <= 300; i++) begin
      sample_valid = 1'b0; frame_done = 1'b1;
      tick();  // RUN -> ARM
      frame_done = 1'b0;
      if (i == 10 || i == 255 || i == 300) begin
        checks++;
        if (underruns !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++;
          $display("FAIL underrun_count[%0d]: got %0d want %0d", i, underruns,
                   (i > 255) ? 255 : i);
        end
      end
      if (i < 300) begin
        sample_valid = 1'b1;
        tick();  // ARM -> RUN
      end
    end
    tick();
    checks++;
    if ({running, sr_hold, cfg_ready, sr_start, underruns} !== {4'b0000, 8'd255}) begin
      errors++;
      $display("FAIL underrun_final: run=%b hold=%b ready=%b start=%b count=%0d want 0 0 0 0 255",
               running, sr_hold, cfg_ready, sr_start, underruns);
    end
  endtask

  task automatic test_reset_in_settle();
    enable = 1'b0;
    tick();  // ARM -> IDLE
    cfg_valid = 1'b1; cfg_rate = 2'd2; cfg_size = 3'd0;
    tick();  // IDLE -> APPLY
    cfg_valid = 1'b0;
    tick();  // APPLY -> SETTLE
    checks++;
    if ({audio_clk_sel, sample_size} !== {2'd2, 3'd0}) begin
      errors++;
      $display("FAIL pre_reset_apply: clk_sel=%0d size=%0d want 2 0", audio_clk_sel, sample_size);
    end
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cfg_ready, sr_hold, sr_start, running, cfg_err, audio_clk_sel, sample_size, underruns}
        !== {5'b11000, 2'd0, 3'd3, 8'd0}) begin
      errors++;
      $display("FAIL mid_settle_reset: ready=%b hold=%b start=%b run=%b err=%b clk_sel=%0d size=%0d count=%0d",
               cfg_ready, sr_hold, sr_start, running, cfg_err, audio_clk_sel, sample_size, underruns);
    end
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if ({cfg_ready, sr_hold, audio_clk_sel, sample_size} !== {2'b11, 2'd0, 3'd3}) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b hold=%b clk_sel=%0d size=%0d want 1 1 0 3",
               cfg_ready, sr_hold, audio_clk_sel, sample_size);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_back_to_back();
    test_cfg_run();
    test_illegal();
    test_stop_and_cfg();
    test_underrun();
    test_reset_in_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
